// File: rtl/request_unit_if.sv
// Bundle of control-unit requests, memory hits and memory-side request outputs
// seen by request_unit. The slave modport is the request unit's view.
interface request_unit_if #(
  parameter int CNT_W = 32
);
  logic             ctrl_iREN;
  logic             ctrl_dREN;
  logic             ctrl_dWEN;
  logic             ctrl_halt;
  logic             ihit;
  logic             dhit;
  logic [31:0]      alu_addr;
  logic [31:0]      rt_data;
  logic             imemREN;
  logic             dmemREN;
  logic             dmemWEN;
  logic [31:0]      dmemaddr;
  logic [31:0]      dmemstore;
  logic             pc_en;
  logic             halted;
  logic             timeout;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  ctrl_iREN, ctrl_dREN, ctrl_dWEN, ctrl_halt, ihit, dhit, alu_addr, rt_data,
    output imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore, pc_en, halted, timeout, retired
  );

  modport master (
    output ctrl_iREN, ctrl_dREN, ctrl_dWEN, ctrl_halt, ihit, dhit, alu_addr, rt_data,
    input  imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore, pc_en, halted, timeout, retired
  );
endinterface

// File: rtl/request_unit.sv
// Sequences each instruction as a fetch plus optional data access, holding memory
// requests until their hit, and tracks halt, a stuck-access watchdog and retired count.
module request_unit #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input logic           CLK,
  input logic           nRST,
  request_unit_if.slave ru
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {FETCH, MEM, HALT} state_t;

  state_t            state, state_next;
  logic              pc_en, imem_ren, data_req;
  logic              dmem_ren, dmem_wen, halted, timeout;
  logic [31:0]       dmem_addr, dmem_store;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  retired;

  assign data_req = ru.ctrl_dREN || ru.ctrl_dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pc_en      = 1'b0;
    imem_ren   = 1'b0;
    case (state)
      FETCH: begin
        imem_ren = ru.ctrl_iREN;
        if (ru.ihit) begin
          if (ru.ctrl_halt)  state_next = HALT;
          else if (data_req) state_next = MEM;
          else               pc_en      = 1'b1;
        end
      end
      MEM: begin
        if (ru.dhit) begin
          pc_en      = 1'b1;
          state_next = FETCH;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dmem_ren   <= 1'b0;
      dmem_wen   <= 1'b0;
      dmem_addr  <= '0;
      dmem_store <= '0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
      wait_cnt   <= '0;
      retired    <= '0;
    end else begin
      if (state == FETCH && ru.ihit) begin
        if (ru.ctrl_halt) begin
          halted <= 1'b1;
        end else if (data_req) begin
          dmem_addr  <= ru.alu_addr;
          dmem_store <= ru.rt_data;
          // A simultaneous read and write request is resolved as a write.
          dmem_wen   <= ru.ctrl_dWEN;
          dmem_ren   <= ru.ctrl_dREN && !ru.ctrl_dWEN;
        end
      end

      if (state == MEM && ru.dhit) begin
        dmem_ren <= 1'b0;
        dmem_wen <= 1'b0;
      end

      // Counter parks at its last value once the watchdog has fired.
      if (state == MEM && !ru.dhit) begin
        if (wait_cnt == WAIT_LAST) timeout  <= 1'b1;
        else                       wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      if (pc_en && !(&retired)) retired <= retired + CNT_W'(1);
    end
  end

  assign ru.imemREN   = imem_ren;
  assign ru.pc_en     = pc_en;
  assign ru.dmemREN   = dmem_ren;
  assign ru.dmemWEN   = dmem_wen;
  assign ru.dmemaddr  = dmem_addr;
  assign ru.dmemstore = dmem_store;
  assign ru.halted    = halted;
  assign ru.timeout   = timeout;
  assign ru.retired   = retired;

endmodule

// File: doc/request_unit.md
Name: request_unit

Overview:
- Consumer side of the control unit's request outputs (iREN, dREN, dWEN, halt); sits between the control unit and the memory/cache interface in the single-cycle datapath.
- Sequences each instruction as a fetch followed by an optional data access.
- Holds memory requests asserted until the matching hit arrives, latches the data address and store data, and generates pc_en.
- Tracks halt, a stuck-access watchdog, and a retired-instruction count.

Parameters:
- TIMEOUT, 1024, MEM-state wait cycles without dhit before the timeout flag sets.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK  input  1  system clock.
- nRST  input  1  asynchronous active-low reset.
- ctrl_iREN  input  1  control unit instruction-read enable.
- ctrl_dREN  input  1  control unit data-read request for current instruction.
- ctrl_dWEN  input  1  control unit data-write request for current instruction.
- ctrl_halt  input  1  current instruction is HALT.
- ihit  input  1  instruction memory ready.
- dhit  input  1  data memory ready.
- alu_addr  input  32  data address from ALU.
- rt_data  input  32  store data.
- imemREN  output  1  instruction read request.
- dmemREN  output  1  data read request (registered).
- dmemWEN  output  1  data write request (registered).
- dmemaddr  output  32  latched data address.
- dmemstore  output  32  latched store data.
- pc_en  output  1  one-cycle PC advance / register-write commit strobe.
- halted  output  1  sticky halt indicator.
- timeout  output  1  sticky watchdog flag.
- retired  output  CNT_W  count of pc_en pulses, saturating.

Behaviour:
- States: FETCH, MEM, HALT. Reset state is FETCH.
- Reset values: dmemREN=0, dmemWEN=0, dmemaddr=0, dmemstore=0, halted=0, timeout=0, retired=0, wait counter=0.
- Reset is asynchronous, so it can land mid-access. From any state (including MEM with a request outstanding), reset returns to FETCH and drops all requests immediately.
- imemREN = ctrl_iREN when state==FETCH, else 0. This is combinational.
- pc_en is combinational:
  - FETCH: 1 when ihit && !ctrl_halt && !(ctrl_dREN||ctrl_dWEN).
  - MEM: 1 when dhit.
  - Otherwise 0.
- FETCH transitions on ihit:
  - ctrl_halt=1: go to HALT and set halted. Any data request is ignored.
  - Else, ctrl_dREN or ctrl_dWEN set: go to MEM. On the same edge, latch alu_addr into dmemaddr and rt_data into dmemstore, and register dmemREN/dmemWEN from ctrl_dREN/ctrl_dWEN.
  - Else: stay in FETCH; pc_en pulses.
  - No ihit: stay in FETCH with no output changes.
- Both ctrl_dREN and ctrl_dWEN set is illegal. dWEN wins: dmemWEN=1, dmemREN=0.
- MEM:
  - Requests are held stable until dhit.
  - On dhit: pc_en=1 that cycle; dmemREN/dmemWEN clear on the next edge; go to FETCH.
  - dmemaddr and dmemstore keep their values after the access.
- Hits arriving in the wrong state are ignored: dhit in FETCH or HALT, and ihit in MEM or HALT.
- Watchdog:
  - The wait counter increments each MEM cycle without dhit and clears on leaving MEM.
  - When the counter reaches TIMEOUT-1 while still waiting, timeout sets. It is sticky until reset.
  - Requests remain asserted; there is no abort.
- HALT is absorbing until nRST. In HALT: imemREN=0, dmemREN=0, dmemWEN=0, pc_en=0, halted=1.
- retired increments on every cycle with pc_en=1 and saturates at all-ones.

Test Plan:
1. Release reset, ctrl_iREN=1, no data requests, ihit high for 3 cycles -> pc_en=1 for 3 cycles, retired=3, dmemREN=dmemWEN=0.
2. Load: ctrl_dREN=1, alu_addr=0x00000040, ihit -> next cycle dmemREN=1, dmemaddr=0x40, imemREN=0, pc_en=0. dhit after 2 wait cycles -> pc_en=1 that cycle, dmemREN=0 the following cycle, state FETCH, retired+1.
3. Store: ctrl_dWEN=1, alu_addr=0x80, rt_data=0xDEADBEEF -> dmemWEN=1, dmemstore=0xDEADBEEF held until dhit. Also assert dREN and dWEN together -> only dmemWEN=1.
4. Halt: ctrl_halt=1 with ihit -> halted=1 next cycle. ihit/dhit toggled for 10 cycles -> pc_en stays 0, imemREN stays 0, retired unchanged.
5. Watchdog with TIMEOUT=4: load with dhit held low -> timeout=1 after the 4th wait cycle and dmemREN still 1. Late dhit -> completes normally; timeout stays 1.
6. Drive nRST low while in MEM with dmemWEN=1 -> dmemWEN=0, timeout=0, retired=0 asynchronously, before the next CLK edge. After release, FETCH and imemREN follow ctrl_iREN.
